// File: rtl/palette_ram_mp.sv
// Palette RAM with one CPU read/write port and NUM_RD render read ports.
// Includes backdrop mirroring, write-first forwarding, a grayscale mask and a post-reset clear.
module palette_ram_mp #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       ADDR_W    = 5,
   parameter int unsigned       NUM_RD    = 2,
   parameter bit                MIRROR_EN = 1'b1,
   parameter bit                OUT_REG   = 1'b0,
   parameter logic [DATA_W-1:0] INIT_VAL  = DATA_W'(8'h0F),
   parameter logic [DATA_W-1:0] GRAY_MASK = DATA_W'(8'h30)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     grayscale,
   input  logic                     wren,
   input  logic                     rden,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        data_in,
   output logic [DATA_W-1:0]        data_out,
   output logic                     data_valid,
   output logic                     busy,
   input  logic [NUM_RD-1:0]        render_rden,
   input  logic [NUM_RD*ADDR_W-1:0] render_addr,
   output logic [NUM_RD*DATA_W-1:0] render_data,
   output logic [NUM_RD-1:0]        render_valid
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = '1;

   if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("palette_ram_mp: NUM_RD must be in 1..4");
   end

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                busy_q, busy_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                clear_c, mem_we_c, cpu_rd_c;
   logic [ADDR_W-1:0]   cpu_a_c, mem_wa_c;
   logic [DATA_W-1:0]   mem_wd_c, cpu_rdata_c;
   logic [ADDR_W-1:0]   r_addr_c [NUM_RD];
   logic [DATA_W-1:0]   r_val_c  [NUM_RD];

   logic [DATA_W-1:0]        data1_q, data1_d;
   logic                     dv1_q, dv1_d;
   logic [NUM_RD*DATA_W-1:0] rdata1_q, rdata1_d;
   logic [NUM_RD-1:0]        rv1_q, rv1_d;

   // Backdrop aliasing: entries with a[1:0]==0 in the upper half fold onto the lower half.
   function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
      map_addr = a;
      if (MIRROR_EN && (a[1:0] == 2'b00)) map_addr[ADDR_W-1] = 1'b0;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
      busy_d = (state_d == S_CLEAR);
   end

   always_comb begin
      clear_c     = (state_q == S_CLEAR);
      cpu_a_c     = map_addr(addr);
      mem_we_c    = clear_c | wren;
      mem_wa_c    = clear_c ? cnt_q : cpu_a_c;
      mem_wd_c    = clear_c ? INIT_VAL : data_in;
      cpu_rd_c    = ~clear_c & rden;
      cpu_rdata_c = (wren && (mem_wa_c == cpu_a_c)) ? data_in : mem[cpu_a_c];
   end

   // Render lookups: write-first forwarding, then grayscale, forced to zero while clearing.
   always_comb begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
         r_addr_c[i] = map_addr(render_addr[i*ADDR_W +: ADDR_W]);
         r_val_c[i]  = (mem_we_c && (mem_wa_c == r_addr_c[i])) ? mem_wd_c : mem[r_addr_c[i]];
         if (grayscale) r_val_c[i] = r_val_c[i] & GRAY_MASK;
         if (clear_c)   r_val_c[i] = '0;
      end
   end

   always_comb begin
      dv1_d    = cpu_rd_c;
      data1_d  = cpu_rd_c ? cpu_rdata_c : data1_q;
      rv1_d    = render_rden;
      rdata1_d = rdata1_q;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         if (render_rden[i]) rdata1_d[i*DATA_W +: DATA_W] = r_val_c[i];
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we_c) mem[mem_wa_c] <= mem_wd_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data1_q  <= '0;
         dv1_q    <= 1'b0;
         rdata1_q <= '0;
         rv1_q    <= '0;
      end else begin
         data1_q  <= data1_d;
         dv1_q    <= dv1_d;
         rdata1_q <= rdata1_d;
         rv1_q    <= rv1_d;
      end
   end

   if (OUT_REG) begin : g_oreg
      logic [DATA_W-1:0]        data2_q;
      logic                     dv2_q;
      logic [NUM_RD*DATA_W-1:0] rdata2_q;
      logic [NUM_RD-1:0]        rv2_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            data2_q  <= '0;
            dv2_q    <= 1'b0;
            rdata2_q <= '0;
            rv2_q    <= '0;
         end else begin
            data2_q  <= data1_q;
            dv2_q    <= dv1_q;
            rdata2_q <= rdata1_q;
            rv2_q    <= rv1_q;
         end
      end

      assign data_out     = data2_q;
      assign data_valid   = dv2_q;
      assign render_data  = rdata2_q;
      assign render_valid = rv2_q;
   end else begin : g_noreg
      assign data_out     = data1_q;
      assign data_valid   = dv1_q;
      assign render_data  = rdata1_q;
      assign render_valid = rv1_q;
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_palette_ram_mp.sv
// Directed bench: dut_a uses defaults (NUM_RD=2, OUT_REG=0), dut_b uses NUM_RD=3, OUT_REG=1.
module tb_palette_ram_mp;

   logic        clk = 1'b0;
   logic        reset;
   logic        grayscale, wren, rden;
   logic [4:0]  addr;
   logic [7:0]  data_in;

   logic [7:0]  a_data_out;
   logic        a_data_valid, a_busy;
   logic [1:0]  a_render_rden;
   logic [9:0]  a_render_addr;
   logic [15:0] a_render_data;
   logic [1:0]  a_render_valid;

   logic [7:0]  b_data_out;
   logic        b_data_valid, b_busy;
   logic [2:0]  b_render_rden;
   logic [14:0] b_render_addr;
   logic [23:0] b_render_data;
   logic [2:0]  b_render_valid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   palette_ram_mp dut_a (
      .clk(clk), .reset(reset), .grayscale(grayscale), .wren(wren), .rden(rden),
      .addr(addr), .data_in(data_in), .data_out(a_data_out), .data_valid(a_data_valid),
      .busy(a_busy), .render_rden(a_render_rden), .render_addr(a_render_addr),
      .render_data(a_render_data), .render_valid(a_render_valid)
   );

   palette_ram_mp #(.NUM_RD(3), .OUT_REG(1'b1)) dut_b (
      .clk(clk), .reset(reset), .grayscale(grayscale), .wren(wren), .rden(rden),
      .addr(addr), .data_in(data_in), .data_out(b_data_out), .data_valid(b_data_valid),
      .busy(b_busy), .render_rden(b_render_rden), .render_addr(b_render_addr),
      .render_data(b_render_data), .render_valid(b_render_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
      wren = 1'b1; addr = a; data_in = d;
      tick();
      wren = 1'b0;
   endtask

   task automatic cpu_read(input string tag, input logic [4:0] a, input logic [7:0] exp);
      rden = 1'b1; addr = a;
      tick();
      rden = 1'b0;
      check({tag, "_data"}, 32'(a_data_out), 32'(exp));
      check({tag, "_valid"}, 32'(a_data_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int bad;
      reset = 1'b1; grayscale = 1'b0; wren = 1'b0; rden = 1'b0; addr = '0; data_in = '0;
      a_render_rden = '0; a_render_addr = '0; b_render_rden = '0; b_render_addr = '0;
      tick(); tick();

      // T1: reset state
      check("rst_data_out", 32'(a_data_out), 32'h0);
      check("rst_data_valid", 32'(a_data_valid), 32'h0);
      check("rst_render_data", 32'(a_render_data), 32'h0);
      check("rst_render_valid", 32'(a_render_valid), 32'h0);
      check("rst_busy", 32'(a_busy), 32'h1);
      check("rst_b_busy", 32'(b_busy), 32'h1);

      // T1: clear lasts 32 cycles; render reads return 0
      a_render_rden = 2'b11; a_render_addr = {5'h03, 5'h01};
      b_render_rden = 3'b111; b_render_addr = {5'h02, 5'h1F, 5'h00};
      reset = 1'b0;
      n = 0; bad = 0;
      while (a_busy && n < 100) begin
         tick();
         n++;
         if (a_render_data !== 16'h0 || a_render_valid !== 2'b11) bad++;
         if (n > 1 && (b_render_data !== 24'h0 || b_render_valid !== 3'b111)) bad++;
      end
      check("clr_len", 32'(n), 32'd32);
      check("clr_render_zero", 32'(bad), 32'd0);
      check("clr_b_busy_done", 32'(b_busy), 32'd0);
      a_render_rden = '0; b_render_rden = '0;
      tick(); tick();
      check("render_valid_drop", 32'(a_render_valid), 32'h0);

      bad = 0;
      for (int a = 0; a < 32; a++) begin
         rden = 1'b1; addr = 5'(a);
         tick();
         if (a_data_out !== 8'h0F || a_data_valid !== 1'b1) bad++;
      end
      check("init_all_0F", 32'(bad), 32'd0);
      rden = 1'b0;
      tick();
      check("hold_valid", 32'(a_data_valid), 32'h0);
      check("hold_data", 32'(a_data_out), 32'h0F);

      // T2: mirroring
      cpu_write(5'h10, 8'h3F);
      cpu_read("mir_10_00", 5'h00, 8'h3F);
      cpu_write(5'h04, 8'h21);
      cpu_read("mir_04_14", 5'h14, 8'h21);
      cpu_write(5'h11, 8'h33);
      cpu_read("nomir_01", 5'h01, 8'h0F);
      cpu_read("nomir_11", 5'h11, 8'h33);

      // Simultaneous CPU write and read returns the written data
      wren = 1'b1; rden = 1'b1; addr = 5'h02; data_in = 8'h15;
      tick();
      wren = 1'b0; rden = 1'b0;
      check("cpu_rw_same", 32'(a_data_out), 32'h15);

      // T3: render forwarding through alias, both ports same entry
      wren = 1'b1; addr = 5'h0C; data_in = 8'h2A;
      a_render_rden = 2'b11; a_render_addr = {5'h1C, 5'h0C};
      tick();
      wren = 1'b0; a_render_rden = '0;
      check("fwd_render", 32'(a_render_data), 32'h2A2A);
      check("fwd_render_valid", 32'(a_render_valid), 32'h3);

      // T4: grayscale on render path only
      cpu_write(5'h05, 8'h27);
      grayscale = 1'b1; a_render_rden = 2'b01; a_render_addr = {5'h00, 5'h05};
      rden = 1'b1; addr = 5'h05;
      tick();
      grayscale = 1'b0; a_render_rden = '0; rden = 1'b0;
      check("gray_render", 32'(a_render_data[7:0]), 32'h20);
      check("gray_cpu", 32'(a_data_out), 32'h27);
      check("gray_valid", 32'(a_render_valid), 32'h1);
      tick();
      check("render_hold_valid", 32'(a_render_valid), 32'h0);
      check("render_hold_data", 32'(a_render_data[7:0]), 32'h20);

      // T5: OUT_REG=1, three ports, latency 2
      cpu_write(5'h01, 8'h12);
      cpu_write(5'h02, 8'h34);
      b_render_rden = 3'b111; b_render_addr = {5'h01, 5'h02, 5'h01};
      rden = 1'b1; addr = 5'h02;
      tick();
      b_render_rden = '0; rden = 1'b0;
      check("oreg_lat1_rvalid", 32'(b_render_valid), 32'h0);
      check("oreg_lat1_dvalid", 32'(b_data_valid), 32'h0);
      tick();
      check("oreg_rvalid", 32'(b_render_valid), 32'h7);
      check("oreg_rdata", 32'(b_render_data), 32'h123412);
      check("oreg_dvalid", 32'(b_data_valid), 32'h1);
      check("oreg_data", 32'(b_data_out), 32'h34);

      // T6: reset at cnt=10 during clear restarts the full clear
      reset = 1'b1; tick(); reset = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("mid_busy", 32'(a_busy), 32'h1);
      reset = 1'b1;
      #1;
      check("mid_rst_data_out", 32'(a_data_out), 32'h0);
      tick();
      reset = 1'b0;
      rden = 1'b1; addr = 5'h05; data_in = 8'h55;
      n = 0; bad = 0;
      while (a_busy && n < 100) begin
         wren = (n == 20);
         tick();
         n++;
         if (a_data_valid !== 1'b0) bad++;
      end
      wren = 1'b0;
      check("clr2_len", 32'(n), 32'd32);
      check("clr2_no_cpu_valid", 32'(bad), 32'd0);
      check("clr2_b_busy", 32'(b_busy), 32'd0);
      tick();
      rden = 1'b0;
      check("clr2_wren_ignored", 32'(a_data_out), 32'h0F);
      check("clr2_valid", 32'(a_data_valid), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
